// File: rtl/cosim_ep_out_fifo_pkg.sv
// Shared helpers and types for the cosim endpoint FIFOs.
package cosim_fifo_pkg;

  typedef struct packed {
    logic [31:0] xfers;
    logic [7:0]  high_water;
  } cosim_fifo_stats_t;

  // Pointer width for a given entry count, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cosim_ep_out_fifo_if.sv
// Handshake bundle between cosim endpoint DataOut, the elastic FIFO and the DUT consumer.
// COSIM_EP_FIFO_STATS_EN adds the HighWater/XferCount statistics signals.
interface cosim_ep_out_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] InData;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] OutData;
  logic [CW-1:0]    Count;

`ifdef COSIM_EP_FIFO_STATS_EN
  logic [CW-1:0]    HighWater;
  logic [31:0]      XferCount;

  modport slave (
    input  InValid, InData, OutReady,
    output InReady, OutValid, OutData, Count, HighWater, XferCount
  );
  modport master (
    output InValid, InData, OutReady,
    input  InReady, OutValid, OutData, Count, HighWater, XferCount
  );
`else
  modport slave (
    input  InValid, InData, OutReady,
    output InReady, OutValid, OutData, Count
  );
  modport master (
    output InValid, InData, OutReady,
    input  InReady, OutValid, OutData, Count
  );
`endif

endinterface

// File: rtl/cosim_ep_out_fifo_ram.sv
// WIDTH x DEPTH register array: one synchronous write port, combinational read by address.
module cosim_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; occupancy lives in the controller.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cosim_ep_out_fifo.sv
// First-word-fall-through elastic FIFO between a cosim endpoint DataOut channel and the DUT.
// COSIM_EP_FIFO_STATS_EN adds HighWater (peak occupancy) and XferCount (pops since reset).
module cosim_ep_out_fifo
  import cosim_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rstn,
  cosim_ep_out_fifo_if.slave  bus
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          in_ready;
  logic          out_valid;
  logic          push;
  logic          pop;

  // Ready/valid derive only from the registered count, so there is no in->out comb path.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = bus.InValid & in_ready;
  assign pop       = out_valid & bus.OutReady;

  assign bus.InReady  = in_ready;
  assign bus.OutValid = out_valid;
  assign bus.Count    = count_q;

  cosim_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.InData),
    .raddr (rd_ptr),
    .rdata (bus.OutData)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef COSIM_EP_FIFO_STATS_EN
  logic [CW-1:0] high_water;
  logic [31:0]   xfer_count;

  // Peak tracks the registered count, so it lags a rise by one cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      high_water <= '0;
      xfer_count <= '0;
    end else begin
      if (count_q > high_water) high_water <= count_q;
      if (pop) xfer_count <= xfer_count + 32'd1;
    end
  end

  assign bus.HighWater = high_water;
  assign bus.XferCount = xfer_count;
`endif

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (!rstn)
    !(push && (count_q == FULL)));
  a_count_range: assert property (@(posedge clk) disable iff (!rstn)
    count_q <= FULL);
  a_head_stable: assert property (@(posedge clk) disable iff (!rstn)
    (out_valid && !bus.OutReady) |=> $stable(bus.OutData));
`endif

endmodule

// File: tb/tb_cosim_ep_out_fifo.sv
// Directed bench for cosim_ep_out_fifo (DEPTH=4); COSIM_EP_FIFO_STATS_EN also checks the stats outputs.
module tb_cosim_ep_out_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int NMSG  = 1000;

  logic clk;
  logic rstn;

  int n_checks = 0;
  int n_err    = 0;

  cosim_ep_out_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  cosim_ep_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] q[$];
  int sent, recv, maxc, cyc;
  logic acc, do_push, do_pop;
  logic [WIDTH-1:0] d;

  initial begin
    rstn         = 1'b0;
    bus.InValid  = 1'b1;
    bus.InData   = 32'h55;
    bus.OutReady = 1'b0;

    // 1. reset held three cycles with InValid asserted
    repeat (3) begin
      tick();
      check("rst_outvalid", bus.OutValid, 0);
      check("rst_count", bus.Count, 0);
    end
    bus.InValid = 1'b0;
    rstn = 1'b1;
    tick();
    check("rel_inready", bus.InReady, 1);
    check("rel_count", bus.Count, 0);

    // 2. single message with one-cycle latency
    bus.InValid  = 1'b1;
    bus.InData   = 32'hDEADBEEF;
    bus.OutReady = 1'b1;
    tick();
    bus.InValid = 1'b0;
    check("single_valid", bus.OutValid, 1);
    check("single_data", bus.OutData, 32'hDEADBEEF);
    check("single_count", bus.Count, 1);
    tick();
    check("single_count_after", bus.Count, 0);
    check("single_valid_after", bus.OutValid, 0);
    bus.OutReady = 1'b0;

    // 3. fill to full, fifth word held off, then drain in order
    for (int i = 1; i <= 4; i++) begin
      bus.InValid = 1'b1;
      bus.InData  = WIDTH'(i);
      tick();
    end
    bus.InData = 32'h5;
    check("full_count", bus.Count, 4);
    check("full_inready", bus.InReady, 0);
    tick();
    tick();
    check("held_count", bus.Count, 4);
    check("held_head", bus.OutData, 32'h1);
    bus.OutReady = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      check("drain_valid", bus.OutValid, 1);
      check("drain_data", bus.OutData, 64'(k));
      acc = bus.InValid & bus.InReady;
      tick();
      if (acc) bus.InValid = 1'b0;
    end
    check("drain_empty", bus.Count, 0);
    check("drain_valid_end", bus.OutValid, 0);
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;

    // 4. simultaneous push/pop at Count=2, pointers wrap repeatedly
    for (int i = 0; i < 2; i++) begin
      bus.InValid = 1'b1;
      bus.InData  = 32'd100 + 32'(i);
      tick();
    end
    bus.InValid = 1'b0;
    check("pp_pre_count", bus.Count, 2);
    for (int k = 0; k < 10; k++) begin
      bus.InValid  = 1'b1;
      bus.InData   = 32'd102 + 32'(k);
      bus.OutReady = 1'b1;
      check("pp_count", bus.Count, 2);
      check("pp_data", bus.OutData, 64'(100 + k));
      tick();
    end
    bus.InValid = 1'b0;
    check("pp_post_count", bus.Count, 2);
    for (int k = 0; k < 2; k++) begin
      check("pp_tail", bus.OutData, 64'(110 + k));
      tick();
    end
    check("pp_empty", bus.Count, 0);
    bus.OutReady = 1'b0;

    // 5. reset with three entries held
    for (int i = 1; i <= 3; i++) begin
      bus.InValid = 1'b1;
      bus.InData  = 32'h11 * 32'(i);
      tick();
    end
    bus.InValid = 1'b0;
    check("mid_pre_count", bus.Count, 3);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("mid_count", bus.Count, 0);
    check("mid_valid", bus.OutValid, 0);
    check("mid_inready", bus.InReady, 1);
    bus.InValid = 1'b1;
    bus.InData  = 32'hA5;
    tick();
    bus.InValid = 1'b0;
    check("mid_first_valid", bus.OutValid, 1);
    check("mid_first_data", bus.OutData, 32'hA5);
    check("mid_first_count", bus.Count, 1);
    bus.OutReady = 1'b1;
    tick();
    check("mid_popped", bus.Count, 0);
    bus.OutReady = 1'b0;

    // 6. random backpressure against a queue model
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    sent = 0;
    recv = 0;
    maxc = 0;
    cyc  = 0;
    while ((recv < NMSG) && (cyc < 20000)) begin
      check("rnd_count", bus.Count, 64'(q.size()));
      check("rnd_valid", bus.OutValid, 64'(q.size() != 0));
      check("rnd_inready", bus.InReady, 64'(q.size() != DEPTH));
      if (q.size() != 0) check("rnd_data", bus.OutData, q[0]);
      d = WIDTH'($urandom);
      bus.InValid  = (sent < NMSG) && ($urandom_range(1, 0) == 1);
      bus.InData   = d;
      bus.OutReady = ($urandom_range(1, 0) == 1);
      do_push = bus.InValid && (q.size() != DEPTH);
      do_pop  = bus.OutReady && (q.size() != 0);
      tick();
      if (do_pop) begin
        void'(q.pop_front());
        recv++;
      end
      if (do_push) begin
        q.push_back(d);
        sent++;
      end
      if (q.size() > maxc) maxc = q.size();
      cyc++;
    end
    check("rnd_received", 64'(recv), 64'(NMSG));
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    tick();
    check("rnd_final_count", bus.Count, 0);
`ifdef COSIM_EP_FIFO_STATS_EN
    check("stats_xfers", bus.XferCount, 64'(NMSG));
    check("stats_high_water", bus.HighWater, 64'(maxc));
    check("stats_hw_bound", 64'(bus.HighWater <= DEPTH), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
